mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's 15-bit memory address bus.
- Accepts a single-word read or write request, addressed by the value the address register drives.
- Holds the word array and inserts a configurable number of wait states.
- Returns a one-cycle acknowledge with read data, or an error flag for an unimplemented address.

Parameters:
ADDR_W, 15, address width; matches the CPU address bus.
DATA_W, 16, data word width.
DEPTH, 4096, number of implemented words (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_W.
WAIT, 2, wait-state cycles inserted before each access commits (0..15).

Ports:
clk  input  1  system clock, all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  1  request strobe; sampled only in IDLE.
wr  input  1  1 = write, 0 = read; sampled with req.
addr  input  ADDR_W  word address; sampled with req.
wdata  input  DATA_W  write data; sampled with req.
rdata  output  DATA_W  read data; valid while ack=1 for a read.
ack  output  1  one-cycle completion pulse.
err  output  1  out-of-range flag; high only together with ack.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE; ack = 0, err = 0, busy = 0, rdata = 0; wait counter = 0.
  - Memory array contents are not reset.
- States:
  - IDLE: busy=0. If req=1 at a rising edge, capture addr, wr, wdata into internal registers, load counter = WAIT, go to ACCESS.
  - ACCESS: busy=1; req, addr, wr and wdata inputs are ignored.
    - If counter != 0 at an edge, decrement the counter.
    - If counter == 0 at an edge, perform the access and go to RESP.
  - RESP: busy=1, ack=1 for exactly this one cycle. Next edge returns to IDLE, ack=0, err=0.
- Access at commit edge:
  - Captured addr < DEPTH, write: mem[addr] <= wdata; rdata unchanged; err=0.
  - Captured addr < DEPTH, read: rdata <= mem[addr]; err=0.
  - Captured addr >= DEPTH: no array access; err=1 in RESP. A read drives rdata=0; a write leaves rdata unchanged.
- Latency:
  - A request sampled at edge k commits at edge k+WAIT+1.
  - ack is high in the cycle following edge k+WAIT+1.
  - Total occupancy is WAIT+2 cycles (WAIT=0 gives ack one cycle after acceptance).
- Back-to-back: a req held high through RESP is not accepted in RESP. It is accepted at the first edge in IDLE, so the minimum request spacing is WAIT+3 cycles.
- rdata holds its last read value between reads; it is not cleared by ack falling.
- The only address compare is captured addr >= DEPTH. Only the address bits needed for the index are used beyond that (no aliasing for in-range addresses).
- Reset mid-operation:
  - Asserted before the commit edge: the access is aborted and memory is not modified.
  - Asserted after the commit edge: the write stands.
  - Outputs return to reset values immediately (asynchronous).
- Simultaneous req and rst_n low: reset wins; the request is dropped.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, req=0 -> busy=0, ack=0, err=0, rdata=0 throughout.
- Write/read round trip (WAIT=2): write addr=0x0010 wdata=0xBEEF accepted at edge k -> ack high in cycle after edge k+3, err=0. Then read addr=0x0010 -> ack with rdata=0xBEEF after 3 edges; busy high for exactly 4 cycles per request.
- Out of range (DEPTH=4096):
  - Read addr=0x1000 -> ack=1, err=1, rdata=0.
  - Write addr=0x7FFF wdata=0x1234 -> ack=1, err=1, no array word changed (read back of addr 0x0FFF unchanged).
- Input changes while busy: accept read of addr=0x0010. During ACCESS, change addr to 0x0020 and wr to 1, and pulse req -> response returns mem[0x0010]; no write occurs; only one ack.
- Held req: req=1 continuously with reads of addr 5 and 6 alternating -> acks spaced exactly WAIT+3 = 5 cycles apart, each with the correct data.
- Reset mid-write: write addr=0x0003 wdata=0xAAAA over old 0x5555. Assert rst_n low during ACCESS before the commit edge -> outputs zero immediately; later read of 0x0003 returns 0x5555.

Source files
------------

// File: rtl/mem_responder.sv
// Single-word memory responder: accepts one read or write, waits WAIT cycles,
// commits the access, then pulses ack (with err for unimplemented addresses).
module mem_responder #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_wr;
    logic [DATA_W-1:0] cap_wdata;
    logic              err_q;
    logic              in_range;
    logic              commit;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = ({1'b0, cap_addr} < DEPTH_L);
    assign idx      = cap_addr[IDX_W-1:0];
    assign commit   = (state == ACCESS) && (cnt == 4'd0);

    assign ack  = (state == RESP);
    assign err  = err_q;
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_wr    <= 1'b0;
            cap_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr  <= addr;
                        cap_wr    <= wr;
                        cap_wdata <= wdata;
                        cnt       <= 4'(WAIT);
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q <= !in_range;
                        if (!cap_wr) rdata <= in_range ? mem[idx] : '0;
                    end
                end
                RESP:    err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

    // NOTE: the array has no reset; clearing thousands of words is not wanted and
    // an async reset clears state first, so an aborted access never reaches here.
    always_ff @(posedge clk) begin
        if (commit && cap_wr && in_range) mem[idx] <= cap_wdata;
    end

endmodule
